// File: rtl/sha3_512_feeder.sv
// Byte-serial to 64-bit big-endian word feeder for the sha3_512 core, with digest capture/hold.
// Define SHA3_FEEDER_AUTORST_EN to pulse core_reset for one cycle before every message.
module sha3_512_feeder #(
    parameter int unsigned DIGEST_BITS = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    input  logic                   s_empty,
    output logic                   s_ready,
    output logic [63:0]            core_in,
    output logic                   core_in_ready,
    output logic                   core_is_last,
    output logic [2:0]             core_byte_num,
    input  logic                   core_buffer_full,
    input  logic [DIGEST_BITS-1:0] core_out,
    input  logic                   core_out_ready,
    output logic                   core_reset,
    output logic [DIGEST_BITS-1:0] digest,
    output logic                   digest_valid,
    input  logic                   digest_ready
);

`ifdef SHA3_FEEDER_AUTORST_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FILL, S_SEND, S_SEND_PAD, S_WAIT, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SEND, S_SEND_PAD, S_WAIT, S_DONE
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [63:0]            word_q, word_d;
    logic                   last_q, last_d;
    logic [2:0]             bn_q, bn_d;
    logic                   pad_q, pad_d;
    logic [DIGEST_BITS-1:0] digest_q, digest_d;
    logic                   dv_q, dv_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            bn_q     <= '0;
            pad_q    <= 1'b0;
            digest_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            last_q   <= last_d;
            bn_q     <= bn_d;
            pad_q    <= pad_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        last_d        = last_q;
        bn_d          = bn_q;
        pad_d         = pad_q;
        digest_d      = digest_q;
        dv_d          = dv_q;
        s_ready       = 1'b0;
        core_in_ready = 1'b0;
        core_reset    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
`ifdef SHA3_FEEDER_AUTORST_EN
                    state_d = S_CLR;
`else
                    state_d = S_FILL;
`endif
                end
            end
`ifdef SHA3_FEEDER_AUTORST_EN
            S_CLR: begin
                core_reset = 1'b1;
                state_d    = S_FILL;
            end
`endif
            S_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last && s_empty) begin
                        last_d  = 1'b1;
                        bn_d    = cnt_q;
                        state_d = S_SEND;
                    end else begin
                        // Word is cleared on every hand-off, so OR-ing places the byte and keeps unused bytes 0.
                        word_d = word_q | ({s_data, 56'h0} >> {cnt_q, 3'b000});
                        if (s_last) begin
                            if (cnt_q == 3'd7) begin
                                last_d = 1'b0;
                                bn_d   = '0;
                                pad_d  = 1'b1;
                            end else begin
                                last_d = 1'b1;
                                bn_d   = cnt_q + 3'd1;
                            end
                            state_d = S_SEND;
                        end else if (cnt_q == 3'd7) begin
                            state_d = S_SEND;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
            end
            S_SEND, S_SEND_PAD: begin
                core_in_ready = 1'b1;
                if (!core_buffer_full) begin
                    word_d = '0;
                    cnt_d  = '0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        bn_d    = '0;
                        state_d = S_WAIT;
                    end else if (pad_q) begin
                        pad_d   = 1'b0;
                        last_d  = 1'b1;
                        bn_d    = '0;
                        state_d = S_SEND_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_WAIT: begin
                if (core_out_ready) begin
                    digest_d = core_out;
                    dv_d     = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (digest_ready) begin
                    dv_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_in       = word_q;
    assign core_byte_num = bn_q;
    assign core_is_last  = core_in_ready & last_q;
    assign digest        = digest_q;
    assign digest_valid  = dv_q;

endmodule

// File: tb/tb_sha3_512_feeder.sv
// Directed bench for sha3_512_feeder: the bench stands in for the sha3_512 core and records
// every word it takes, then compares against hand-computed words and injected digests.
module tb_sha3_512_feeder;

    localparam logic [511:0] PAT_FOX   = {8{64'hD01DEDD5_A5A50001}};
    localparam logic [511:0] PAT_EMPTY = {8{64'h0EAB42DE_5A5A0002}};
    localparam logic [511:0] PAT_64    = {8{64'hCCD91653_C3C30003}};
    localparam logic [511:0] PAT_JUNK  = {8{64'hDEADBEEF_FFFF0000}};

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   s_data;
    logic         s_valid, s_last, s_empty, s_ready;
    logic [63:0]  core_in;
    logic         core_in_ready, core_is_last;
    logic [2:0]   core_byte_num;
    logic         core_buffer_full;
    logic [511:0] core_out;
    logic         core_out_ready, core_reset;
    logic [511:0] digest;
    logic         digest_valid, digest_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] w_data[$];
    logic        w_last[$];
    logic [2:0]  w_bn[$];
    int          nlast = 0;

    always #5 clk = ~clk;

    sha3_512_feeder #(.DIGEST_BITS(512)) dut (
        .clk              (clk),
        .reset            (reset),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .s_empty          (s_empty),
        .s_ready          (s_ready),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .core_reset       (core_reset),
        .digest           (digest),
        .digest_valid     (digest_valid),
        .digest_ready     (digest_ready)
    );

    // Core stand-in: a word is taken on the coming edge when in_ready is high and the buffer is not full.
    always @(negedge clk) begin
        #4;
        if (reset && core_in_ready && !core_buffer_full) begin
            w_data.push_back(core_in);
            w_last.push_back(core_is_last);
            w_bn.push_back(core_byte_num);
            if (core_is_last) nlast++;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_words();
        w_data.delete();
        w_last.delete();
        w_bn.delete();
        nlast = 0;
    endtask

    task automatic expect_word(input int idx, input logic [63:0] d, input logic l, input logic [2:0] bn);
        logic [63:0] gd;
        logic        gl;
        logic [2:0]  gb;
        gd = 'x; gl = 'x; gb = 'x;
        if (idx < w_data.size()) begin
            gd = w_data[idx]; gl = w_last[idx]; gb = w_bn[idx];
        end
        check($sformatf("word%0d_data", idx), gd, d);
        check($sformatf("word%0d_last", idx), gl, l);
        check($sformatf("word%0d_bnum", idx), gb, bn);
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", s_ready, 0);
        check("rst_core_in_ready", core_in_ready, 0);
        check("rst_core_is_last", core_is_last, 0);
        check("rst_digest_valid", digest_valid, 0);
        check("rst_core_reset", core_reset, 0);
        check("rst_core_in", core_in, 0);
        check("rst_core_byte_num", core_byte_num, 0);
        check("rst_digest", digest, 0);
    endtask

    // Called at a negedge; returns at the negedge right after the acceptance edge.
    task automatic push(input logic [7:0] d, input logic l, input logic e, output int waits);
        s_data = d; s_last = l; s_empty = e; s_valid = 1'b1;
        waits = 0;
        while (!s_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!s_ready) check("push_timeout", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; s_data = '0;
    endtask

    task automatic wait_last_word();
        int n;
        n = 0;
        while (nlast == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("last_word_seen", (nlast != 0), 1);
    endtask

    task automatic finish_msg(input logic [511:0] pat);
        wait_last_word();
        core_out = pat;
        core_out_ready = 1'b1;
        check("dv_before_out_ready", digest_valid, 0);
        @(negedge clk);
        core_out_ready = 1'b0;
        core_out = PAT_JUNK;
        check("dv_rise", digest_valid, 1);
        check("digest_capture", digest, pat);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        check("dv_fall", digest_valid, 0);
    endtask

    initial begin
        string       fox;
        logic [63:0] fox_words[6];
        logic [7:0]  rep[8];
        logic [511:0] held;
        int          w;
        int          first_wait;

        fox = "The quick brown fox jumps over the lazy dog";
        fox_words = '{64'h5468652071756963, 64'h6B2062726F776E20, 64'h666F78206A756D70,
                      64'h73206F7665722074, 64'h6865206C617A7920, 64'h646F670000000000};
        rep = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hAB, 8'hCD, 8'hEF};

        reset = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
        core_buffer_full = 1'b0; core_out = '0; core_out_ready = 1'b0; digest_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        // Fox message; core_out_ready held high early must be ignored outside WAIT.
        clear_words();
        core_out = PAT_JUNK;
        core_out_ready = 1'b1;
        first_wait = 0;
        for (int i = 0; i < 43; i++) begin
            push(fox[i], (i == 42), 1'b0, w);
            if (i == 0) first_wait = w;
            if (i == 3) begin
                check("out_ready_ignored_dv", digest_valid, 0);
                check("out_ready_ignored_digest", digest, 0);
                core_out_ready = 1'b0;
            end
        end
`ifdef SHA3_FEEDER_AUTORST_EN
        check("first_byte_latency", first_wait, 2);
`else
        check("first_byte_latency", first_wait, 1);
`endif
        check("fox_last_in_ready", core_in_ready, 1);
        check("fox_last_is_last", core_is_last, 1);
        check("fox_last_byte_num", core_byte_num, 3);
        check("fox_last_core_in", core_in, 64'h646F670000000000);
        finish_msg(PAT_FOX);
        check("fox_word_count", w_data.size(), 6);
        for (int i = 0; i < 6; i++)
            expect_word(i, fox_words[i], (i == 5), (i == 5) ? 3'd3 : 3'd0);

        // Empty message.
        clear_words();
        push(8'hA5, 1'b1, 1'b1, w);
        check("empty_in_ready", core_in_ready, 1);
        check("empty_is_last", core_is_last, 1);
        finish_msg(PAT_EMPTY);
        check("empty_word_count", w_data.size(), 1);
        expect_word(0, 64'h0, 1'b1, 3'd0);

        // 64 repeating bytes, first word stalled by buffer_full for 5 cycles.
        clear_words();
        core_buffer_full = 1'b1;
        for (int i = 0; i < 8; i++) push(rep[i], 1'b0, 1'b0, w);
        for (int c = 0; c < 5; c++) begin
            check("stall_core_in", core_in, 64'h1234567890ABCDEF);
            check("stall_in_ready", core_in_ready, 1);
            check("stall_s_ready", s_ready, 0);
            check("stall_no_take", w_data.size(), 0);
            @(negedge clk);
        end
        core_buffer_full = 1'b0;
        @(negedge clk);
        check("stall_taken_once", w_data.size(), 1);
        for (int i = 8; i < 64; i++) push(rep[i % 8], (i == 63), 1'b0, w);
        check("full_last_in_ready", core_in_ready, 1);
        check("full_last_not_last", core_is_last, 0);
        @(negedge clk);
        check("pad_is_last", core_is_last, 1);
        check("pad_byte_num", core_byte_num, 0);
        check("pad_core_in", core_in, 0);

        // Digest held while the consumer stalls; a waiting source must not be accepted.
        wait_last_word();
        core_out = PAT_64;
        core_out_ready = 1'b1;
        @(negedge clk);
        core_out_ready = 1'b0;
        core_out = PAT_JUNK;
        held = PAT_64;
        s_data = 8'h55; s_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("hold_dv", digest_valid, 1);
            check("hold_digest", digest, held);
            check("hold_s_ready", s_ready, 0);
            @(negedge clk);
        end
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        s_valid = 1'b0;
        check("hold_release_dv", digest_valid, 0);
        check("full_word_count", w_data.size(), 9);
        for (int i = 0; i < 8; i++) expect_word(i, 64'h1234567890ABCDEF, 1'b0, 3'd0);
        expect_word(8, 64'h0, 1'b1, 3'd0);
        @(negedge clk);

        // Reset after 13 bytes, then an empty message.
        clear_words();
        for (int i = 0; i < 13; i++) push(8'(i + 1), 1'b0, 1'b0, w);
        expect_word(0, 64'h0102030405060708, 1'b0, 3'd0);
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);
        clear_words();
        push(8'h00, 1'b1, 1'b1, w);
        finish_msg(PAT_EMPTY);
        check("post_rst_word_count", w_data.size(), 1);
        expect_word(0, 64'h0, 1'b1, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
